hyperbus_rx_deser: RTL
======================

HYPERBUS_RX_DESER -- requirements
Module: hyperbus_rx_deser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output FIFO depth in 16-bit words (power of 2, >=2).
REQ-002 SHALL have parameter LEN_W, default 16, width of the word-count input.
REQ-003 SHALL have port clk_i  input  1  sampling clock, >=4x bus CK frequency.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr_i  input  1  synchronous abort/flush.
REQ-006 SHALL have port start_i  input  1  one-cycle pulse, begins a read burst.
REQ-007 SHALL have port len_i  input  LEN_W  number of 16-bit words to receive, sampled on start_i.
REQ-008 SHALL have port dq_i  input  8  HyperBus DQ, asynchronous to clk_i.
REQ-009 SHALL have port rwds_i  input  1  HyperBus read strobe, asynchronous to clk_i.
REQ-010 SHALL have port data_o  output  16  received word, first byte in [15:8].
REQ-011 SHALL have port valid_o  output  1  data_o valid.
REQ-012 SHALL have port ready_i  input  1  downstream accept; transfer when valid_o & ready_i.
REQ-013 SHALL have port busy_o  output  1  high outside IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse at burst completion.
REQ-015 SHALL have port ovf_o  output  1  sticky FIFO-overflow flag.

Function
REQ-016 SHALL register rwds_i through 3 flops (q1,q2,q3) and dq_i through 2 flops, so dq stage 2 aligns with rwds q2.
REQ-017 SHALL detect an RWDS edge (either polarity) when q2 != q3; RWDS edges SHALL be at least 2 clk_i cycles apart.
REQ-018 SHALL use FSM states IDLE, RECV, DRAIN.
REQ-019 IDLE: start_i with len_i!=0 -> RECV; remaining counter loads len_i, byte phase clears, ovf_o clears.
REQ-020 IDLE: start_i with len_i==0 -> done_o pulse next cycle, remain in IDLE.
REQ-021 IDLE/DRAIN: RWDS edges SHALL be ignored; start_i outside IDLE SHALL be ignored.
REQ-022 RECV: on each edge capture aligned dq; phase 0 -> byte into [15:8], phase 1 -> byte into [7:0] and push word to FIFO, then decrement remaining.
REQ-023 RECV: push decrementing remaining from 1 to 0 -> DRAIN.
REQ-024 DRAIN: FIFO empty -> done_o pulse for one cycle, -> IDLE same edge.
REQ-025 A word SHALL appear on valid_o (FIFO previously empty) exactly 2 clk_i cycles after the clk_i edge that first samples the completing RWDS transition into q1.
REQ-026 FIFO SHALL be first-word-fall-through; data_o stable while valid_o & !ready_i.
REQ-027 Push while full without same-cycle pop SHALL drop the word, set ovf_o, and still decrement remaining.
REQ-028 Push while full with same-cycle pop SHALL be accepted, no overflow.
REQ-029 clr_i SHALL flush FIFO, clear phase/counter/ovf_o, force IDLE, suppress done_o; clr_i overrides start_i in the same cycle.

Reset
REQ-030 On rst_ni low: state IDLE, valid_o 0, busy_o 0, done_o 0, ovf_o 0, data_o 0, FIFO empty, all sync flops 0, counter 0, phase 0.
REQ-031 Reset mid-burst SHALL abort with no done_o pulse; first RWDS edge after release SHALL NOT be detected spuriously (q1..q3 reset equal).

Structure
REQ-032 SHALL place state enum and FIFO_DEPTH/LEN_W defaults in shared package hyperbus_rx_pkg.
REQ-033 SHALL instantiate one sub-module hyperbus_rx_fifo (synchronous FWFT FIFO, push/pop/full/empty, pointer wrap modulo FIFO_DEPTH).

Verification
REQ-034 len_i=2, RWDS toggles every 4 cycles with DQ 0xA1,0xB2,0xC3,0xD4, ready_i=1 -> words 0xA1B2, 0xC3D4, then done_o once, busy_o low.
REQ-035 len_i=0 start_i -> done_o pulse next cycle, busy_o never high, no valid_o.
REQ-036 len_i=6, ready_i=0, FIFO_DEPTH=4 -> 4 words held, words 5-6 dropped, ovf_o=1; then ready_i=1 -> 4 words out, done_o after last pop.
REQ-037 clr_i after 3 bytes of len_i=4 -> valid_o 0, busy_o 0, no done_o; new start_i len_i=1 with bytes 0x55,0xAA -> 0x55AA.
REQ-038 rst_ni low mid-RECV with rwds_i high, release with rwds_i high -> no capture, outputs at reset values.
REQ-039 Full FIFO, ready_i=1 same cycle as push -> no ovf_o, word order preserved across pointer wrap.

Source files
------------

// File: rtl/hyperbus_rx_pkg.sv
// Shared types and defaults for the HyperBus read-data deserializer.
package hyperbus_rx_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 32'd4;
    localparam int unsigned LEN_W_DEF      = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // The first byte on the bus is the most significant byte of the word.
    function automatic logic [15:0] pack_word(input logic [7:0] first_b, input logic [7:0] second_b);
        return {first_b, second_b};
    endfunction

endpackage

// File: rtl/hyperbus_rx_fifo.sv
// First-word-fall-through word FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module hyperbus_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [15:0] data_i,
    input  logic        pop_i,
    output logic [15:0] data_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic          wr_s, rd_s;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == {(AW+1){1'b0}});
    assign data_o  = mem_q[rptr_q];

    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    always_comb begin
        rd_s   = pop_i & ~empty_o;
        wr_s   = push_i & (~full_o | rd_s);
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = {AW{1'b0}};
            rptr_d = {AW{1'b0}};
            cnt_d  = {(AW+1){1'b0}};
        end else begin
            if (wr_s) begin
                mem_d[wptr_q] = data_i;
                wptr_d        = wptr_q + AW'(1);
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_s) begin
                rptr_d = rptr_q + AW'(1);
            end else begin
                rptr_d = rptr_q;
            end
            case ({wr_s, rd_s})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= {AW{1'b0}};
            rptr_q <= {AW{1'b0}};
            cnt_q  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/hyperbus_rx_deser.sv
// HyperBus read-path deserializer: oversamples DQ/RWDS, pairs DDR bytes into words, buffers them in a FWFT FIFO.
module hyperbus_rx_deser
    import hyperbus_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned LEN_W      = LEN_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [7:0]       dq_i,
    input  logic             rwds_i,
    output logic [15:0]      data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);

    state_e           state_q, state_d;
    logic             rwds1_q, rwds2_q, rwds3_q;
    logic [7:0]       dq1_q, dq2_q;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             phase_q, phase_d;
    logic [7:0]       hi_q, hi_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             edge_s, cap_s, push_s, pop_s, last_s;
    logic             fifo_full_s, fifo_empty_s;

    // dq stage 2 lines up with rwds stage 2, so a detected edge captures the byte sampled with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rwds1_q <= 1'b0;
            rwds2_q <= 1'b0;
            rwds3_q <= 1'b0;
            dq1_q   <= 8'h00;
            dq2_q   <= 8'h00;
        end else begin
            rwds1_q <= rwds_i;
            rwds2_q <= rwds1_q;
            rwds3_q <= rwds2_q;
            dq1_q   <= dq_i;
            dq2_q   <= dq1_q;
        end
    end

    assign edge_s = rwds2_q ^ rwds3_q;
    assign cap_s  = (state_q == ST_RECV) & edge_s;
    assign push_s = cap_s & phase_q;
    assign pop_s  = ready_i & ~fifo_empty_s;
    assign last_s = (remain_q == LEN_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = (start_i && (len_i != {LEN_W{1'b0}})) ? ST_RECV : ST_IDLE;
                ST_RECV:  state_d = (push_s && last_s) ? ST_DRAIN : ST_RECV;
                ST_DRAIN: state_d = fifo_empty_s ? ST_IDLE : ST_DRAIN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A dropped word still consumes one count so the burst length stays in step with the bus.
    always_comb begin
        remain_d = remain_q;
        phase_d  = phase_q;
        hi_d     = hi_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (clr_i) begin
            remain_d = {LEN_W{1'b0}};
            phase_d  = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && (len_i != {LEN_W{1'b0}})) begin
                        remain_d = len_i;
                        phase_d  = 1'b0;
                        ovf_d    = 1'b0;
                    end else begin
                        done_d = start_i;
                    end
                end
                ST_RECV: begin
                    if (cap_s && !phase_q) begin
                        hi_d    = dq2_q;
                        phase_d = 1'b1;
                    end else if (push_s) begin
                        phase_d  = 1'b0;
                        remain_d = remain_q - LEN_W'(1);
                        ovf_d    = ovf_q | (fifo_full_s & ~pop_s);
                    end else begin
                        phase_d = phase_q;
                    end
                end
                ST_DRAIN: done_d = fifo_empty_s;
                default:  done_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            remain_q <= {LEN_W{1'b0}};
            phase_q  <= 1'b0;
            hi_q     <= 8'h00;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            remain_q <= remain_d;
            phase_q  <= phase_d;
            hi_q     <= hi_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        busy_o  = (state_q != ST_IDLE);
        valid_o = ~fifo_empty_s;
        done_o  = done_q;
        ovf_o   = ovf_q;
    end

    hyperbus_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .push_i  (push_s),
        .data_i  (pack_word(hi_q, dq2_q)),
        .pop_i   (pop_s),
        .data_o  (data_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

endmodule
